// File: rtl/hamming_rx_serial.sv
// Serial receiver for Hamming(7,4) codewords framed as start / 7 code bits / stop.
// Optional build macro: HAMMING_RX_CORRECT_EN enables single-bit correction of data_o.
module hamming_rx_serial #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       serial_i,
  output logic [3:0] data_o,
  output logic       valid_o,
  output logic [2:0] syndrome_o,
  output logic       error_o,
  output logic       frame_err_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_OUT
  } state_e;

  logic [1:0]       sync_q, sync_d;
  logic             rx;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [6:0]       code_q, code_d;
  logic [3:0]       data_q, data_d;
  logic [2:0]       syn_q, syn_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  logic [2:0]       syn;
  logic [6:0]       fixed;

  // two-stage synchronizer input; the line idles high
  always_comb begin
    sync_d = {sync_q[0], serial_i};
  end

  assign rx = sync_q[1];

  // syndrome of the received word; bit k-1 of code_q holds position k
  always_comb begin
    syn[0] = code_q[0] ^ code_q[2] ^ code_q[4] ^ code_q[6];
    syn[1] = code_q[1] ^ code_q[2] ^ code_q[5] ^ code_q[6];
    syn[2] = code_q[3] ^ code_q[4] ^ code_q[5] ^ code_q[6];
  end

  // codeword used for data extraction (corrected or raw)
  always_comb begin
`ifdef HAMMING_RX_CORRECT_EN
    fixed = code_q;
    if (syn != 3'd0) begin
      fixed = code_q ^ (7'd1 << (syn - 3'd1));
    end
`else
    fixed = code_q;
`endif
  end

  // frame FSM: next state, bit capture and output register updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    code_d  = code_q;
    data_d  = data_q;
    syn_d   = syn_q;
    err_d   = err_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx) begin
          state_d = ST_START;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d          = '0;
          code_d[bit_q]  = rx;
          bit_d          = bit_q + 3'd1;
          if (bit_q == 3'd6) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (rx) begin
            state_d = ST_OUT;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_OUT: begin
        data_d  = {fixed[6], fixed[5], fixed[4], fixed[2]};
        syn_d   = syn;
        err_d   = |syn;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q  <= '1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      code_q  <= '0;
      data_q  <= '0;
      syn_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      code_q  <= code_d;
      data_q  <= data_d;
      syn_q   <= syn_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_o      = data_q;
  assign syndrome_o  = syn_q;
  assign error_o     = err_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_hamming_rx_serial.sv
// Bench for hamming_rx_serial; honours HAMMING_RX_CORRECT_EN like the design.
module tb_hamming_rx_serial;

  localparam int unsigned CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       serial;
  logic [3:0] data_o;
  logic       valid_o;
  logic [2:0] syndrome_o;
  logic       error_o;
  logic       frame_err_o;

  hamming_rx_serial #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .serial_i   (serial),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .syndrome_o (syndrome_o),
    .error_o    (error_o),
    .frame_err_o(frame_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // observed events, written only by the monitor
  logic [3:0] got_d[$];
  logic [2:0] got_s[$];
  logic       got_e[$];
  int         fe_cnt   = 0;
  int         both_cnt = 0;

  always @(negedge clk) begin
    if (valid_o) begin
      got_d.push_back(data_o);
      got_s.push_back(syndrome_o);
      got_e.push_back(error_o);
    end
    if (frame_err_o) fe_cnt++;
    if (valid_o && frame_err_o) both_cnt++;
  end

  // expectations
  logic [3:0] exp_d[$];
  logic [2:0] exp_s[$];
  logic       exp_e[$];
  int         exp_fe  = 0;
  int         fe_base = 0;
  int         rd      = 0;
  logic [3:0] last_data = 4'd0;

  // reference Hamming(7,4): positions that are powers of two carry parity
  function automatic logic [7:1] encode(input logic [3:0] d);
    logic [7:1] c;
    logic       par;
    c    = '0;
    c[3] = d[0];
    c[5] = d[1];
    c[6] = d[2];
    c[7] = d[3];
    for (int p = 1; p <= 4; p = p * 2) begin
      par = 1'b0;
      for (int j = 1; j <= 7; j++) begin
        if (j != p && (j & p) != 0) par = par ^ c[j];
      end
      c[p] = par;
    end
    return c;
  endfunction

  // syndrome = xor of the indices of all set positions
  function automatic logic [2:0] model_syn(input logic [7:1] c);
    int s;
    s = 0;
    for (int j = 1; j <= 7; j++) begin
      if (c[j]) s = s ^ j;
    end
    return 3'(s);
  endfunction

  function automatic logic [3:0] model_data(input logic [7:1] c);
    logic [7:1] w;
    w = c;
`ifdef HAMMING_RX_CORRECT_EN
    if (model_syn(c) != 3'd0) w[model_syn(c)] = ~w[model_syn(c)];
`endif
    return {w[7], w[6], w[5], w[3]};
  endfunction

  task automatic expect_frame(input logic [7:1] c, input logic stop);
    if (stop) begin
      exp_d.push_back(model_data(c));
      exp_s.push_back(model_syn(c));
      exp_e.push_back(model_syn(c) != 3'd0);
      last_data = model_data(c);
    end else begin
      exp_fe++;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial = b;
    wait_cycles(CPB);
  endtask

  // a bad stop bit is held low just past its sampling point, then released
  task automatic send_frame(input logic [7:1] c, input logic stop);
    send_bit(1'b0);
    for (int j = 1; j <= 7; j++) send_bit(c[j]);
    if (stop) begin
      send_bit(1'b1);
    end else begin
      serial = 1'b0;
      wait_cycles(12);
      serial = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    serial = 1'b1;
    wait_cycles(n);
  endtask

  task automatic check_batch(input string tag);
    int n_got;
    n_got = got_d.size() - rd;
    check_eq({tag, "_nvalid"}, n_got, exp_d.size());
    for (int i = 0; i < exp_d.size() && i < n_got; i++) begin
      check_eq({tag, "_data"}, got_d[rd+i], exp_d[i]);
      check_eq({tag, "_syn"},  got_s[rd+i], exp_s[i]);
      check_eq({tag, "_err"},  got_e[rd+i], exp_e[i]);
    end
    check_eq({tag, "_nferr"}, fe_cnt - fe_base, exp_fe);
    check_eq({tag, "_overlap"}, both_cnt, 0);
    rd = got_d.size();
    exp_d.delete();
    exp_s.delete();
    exp_e.delete();
    fe_base = fe_cnt;
    exp_fe  = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_data"},  data_o, 0);
    check_eq({tag, "_syn"},   syndrome_o, 0);
    check_eq({tag, "_err"},   error_o, 0);
    check_eq({tag, "_valid"}, valid_o, 0);
    check_eq({tag, "_ferr"},  frame_err_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:1] c;
    logic [3:0] d;
    logic       stop;
    int         epos;

    rst_n  = 1'b0;
    serial = 1'b1;
    wait_cycles(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(10);

    // clean frame, data 1011
    c = encode(4'b1011);
    send_frame(c, 1'b1);
    expect_frame(c, 1'b1);
    idle(20);
    check_batch("clean1011");
    check_eq("clean1011_hold", data_o, 4'b1011);

    // position 6 flipped
    c[6] = ~c[6];
    send_frame(c, 1'b1);
    expect_frame(c, 1'b1);
    idle(20);
    check_batch("flip6");
    check_eq("flip6_syn", syndrome_o, 3'b110);
    check_eq("flip6_err", error_o, 1);
`ifdef HAMMING_RX_CORRECT_EN
    check_eq("flip6_data", data_o, 4'b1011);
`else
    check_eq("flip6_data", data_o, 4'b1111);
`endif

    // short start-bit glitch
    serial = 1'b0;
    wait_cycles(4);
    idle(3 * CPB);
    check_batch("glitch");

    // bad stop bit keeps previous data
    c = encode(4'b0101);
    send_frame(c, 1'b0);
    expect_frame(c, 1'b0);
    idle(2 * CPB);
    check_batch("badstop");
    check_eq("badstop_keep", data_o, last_data);

    // reset during the 4th data bit, then a clean frame
    c = encode(4'b1100);
    send_bit(1'b0);
    for (int j = 1; j <= 3; j++) send_bit(c[j]);
    serial = c[4];
    wait_cycles(CPB / 2);
    rst_n = 1'b0;
    wait_cycles(2);
    serial = 1'b1;
    wait_cycles(1);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    last_data = 4'd0;
    idle(3 * CPB);
    check_batch("midreset_quiet");
    c = encode(4'b0110);
    send_frame(c, 1'b1);
    expect_frame(c, 1'b1);
    idle(20);
    check_batch("after_reset");

    // back-to-back frames, no idle gap
    c = encode(4'b0001);
    send_frame(c, 1'b1);
    expect_frame(c, 1'b1);
    c = encode(4'b1110);
    send_frame(c, 1'b1);
    expect_frame(c, 1'b1);
    idle(20);
    check_batch("b2b");

    // line stuck low: one frame error per frame time, abandoned by reset
    serial = 1'b0;
    wait_cycles(420);
    exp_fe = 3;
    rst_n  = 1'b0;
    serial = 1'b1;
    wait_cycles(3);
    rst_n = 1'b1;
    last_data = 4'd0;
    idle(20);
    check_batch("stuck_low");

    // randomized frames: random data, optional single-bit error, occasional bad stop
    for (int n = 0; n < 30; n++) begin
      d    = 4'($urandom_range(0, 15));
      c    = encode(d);
      epos = $urandom_range(0, 10);
      if (epos >= 1 && epos <= 7) c[epos] = ~c[epos];
      stop = ($urandom_range(0, 5) != 0);
      send_frame(c, stop);
      expect_frame(c, stop);
      if (stop) idle($urandom_range(0, 3));
      else      idle(2 * CPB);
    end
    idle(20);
    check_batch("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_rx_serial.md
HAMMING_RX_SERIAL -- requirements
Module: hamming_rx_serial

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit; legal values are even and >= 4.
REQ-002 SHALL have port clk_i, input, width 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_i, input, width 1: reset, synchronous, active-low.
REQ-004 SHALL have port serial_i, input, width 1: asynchronous serial line, idle high.
REQ-005 SHALL have port data_o, output, width 4: decoded data {d4,d3,d2,d1}.
REQ-006 SHALL have port valid_o, output, width 1: one-cycle pulse marking data_o, syndrome_o and error_o valid.
REQ-007 SHALL have port syndrome_o, output, width 3: {s3,s2,s1} of the last frame; nonzero equals the erroneous bit position.
REQ-008 SHALL have port error_o, output, width 1: high when syndrome_o != 0 for the last frame.
REQ-009 SHALL have port frame_err_o, output, width 1: one-cycle pulse on a bad stop bit.

Function
REQ-010 SHALL pass serial_i through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-011 SHALL frame each codeword as start bit 0, 7 codeword bits sent position 1 first, then stop bit 1.
REQ-012 SHALL use codeword layout positions 1..7 = p1,p2,d1,p3,d2,d3,d4.
REQ-013 SHALL compute s1 = xor of positions 1,3,5,7; s2 = xor of 2,3,6,7; s3 = xor of 4,5,6,7.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP, OUT.
REQ-015 IDLE: a synchronized low moves the FSM to START with the bit counter cleared.
REQ-016 START: after CLKS_PER_BIT/2 cycles, resample; low goes to DATA, high (glitch) returns to IDLE with no output.
REQ-017 DATA: sample every CLKS_PER_BIT cycles at mid-bit; after the 7th sample, go to STOP.
REQ-018 STOP: after CLKS_PER_BIT cycles, sample; 1 goes to OUT, 0 pulses frame_err_o for one cycle, goes to IDLE, and leaves data_o/syndrome_o/error_o unchanged.
REQ-019 OUT: register data_o, syndrome_o and error_o, pulse valid_o for exactly one cycle, then return to IDLE.
REQ-020 valid_o and frame_err_o SHALL never be high in the same cycle.
REQ-021 A new start bit SHALL be accepted in the cycle after OUT or after a frame error (back-to-back frames).
REQ-022 Line held low continuously SHALL produce repeated frame_err_o pulses, one per frame time, and no valid_o.

Reset
REQ-023 While rst_n_i is low at a clock edge, the FSM SHALL go to IDLE and the counters and synchronizer SHALL load 1s/zeros as idle.
REQ-024 Reset SHALL drive data_o=0, syndrome_o=0, error_o=0, valid_o=0 and frame_err_o=0.
REQ-025 Reset mid-frame SHALL discard the partial frame; no valid_o follows release.

Configuration
REQ-026 Macro HAMMING_RX_CORRECT_EN defined: a nonzero syndrome SHALL flip the addressed bit before extracting data_o.
REQ-027 Macro HAMMING_RX_CORRECT_EN undefined: data_o SHALL be the raw received d-bits, while syndrome_o and error_o are still reported.

Verification
REQ-028 Data 4'b1011, codeword pos1..7 = 1,0,1,0,1,0,1, CLKS_PER_BIT=16 -> one valid_o, data_o=4'b1011, syndrome_o=0, error_o=0.
REQ-029 Same codeword with position 6 flipped -> syndrome_o=3'b110 and error_o=1; data_o=4'b1011 with the macro defined, 4'b1111 without it.
REQ-030 Start low for 4 cycles then high -> returns to IDLE; no valid_o and no frame_err_o.
REQ-031 Valid codeword with stop bit 0 -> one frame_err_o pulse, no valid_o, previous data_o retained.
REQ-032 rst_n_i low during the 4th data bit, then a clean frame with data 4'b0110 -> exactly one valid_o, data_o=4'b0110.
REQ-033 Two back-to-back frames with no idle gap, data 4'b0001 then 4'b1110 -> two valid_o pulses in order with the matching data_o.
